drs_dac_sched: RTL and testbench
================================

# drs_dac_sched

Scheduler and shadow-register bank for the DRS board serial DAC. It holds the five DRS analog settings (ROFS, OOFS, BIAS, CALP, CALN) and arbitrates value updates from two requesters: the slow-control host and the calibration sequencer. It sends only changed channels as 24-bit words through a serial shifter, then pulses LDACn so all outputs update together. It sits between the slow-control register file and the DAC pins, and also performs the power-up initialisation sequence.

## Interface
Parameters:
- CLK_DIV, 1: clk cycles per SCK half-period (≥1).
- LDAC_W, 2: LDACn low width in clk cycles (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- host_req  in  1  host write request; level, held until host_ack.
- host_ch  in  3  host channel index (0..4).
- host_val  in  16  host DAC code.
- host_ack  out  1  one-cycle accept pulse.
- cal_req / cal_ch / cal_val / cal_ack  in/in/in/out  1/3/16/1  calibration requester; same protocol as host.
- update_all  in  1  rising edge marks all five channels dirty.
- DAC_CS, DAC_SDI, DAC_SCK, DAC_LDACn  out  1 each  DAC serial pins.
- busy  out  1  high while any word or LDAC pulse is in progress.
- done  out  1  one-cycle pulse after each LDAC pulse completes.
- dac_en  out  1  high once initialisation has finished.
- err_ch  out  1  one-cycle pulse when an accepted request carries ch > 4.

## Operation
**Command bytes.** Channels 0..4 use 0x33, 0x37, 0x36, 0x32, 0x31 respectively. The three config words are 0x40, 0x44, 0x45, each with data 0x0000. A transmitted word is {cmd, value}, sent MSB first.

**States.**
- **INIT**
  - Sends channels 0..4 in order, using shadow values (all 0x0000 after reset).
  - Then sends config words 0x40, 0x44, 0x45.
  - Then goes to LDAC.
  - dac_en is set in the cycle LDAC exits.
- **IDLE**
  - If any dirty bit is set, picks the lowest dirty index, clears that bit, and starts the shifter (SEND).
  - Otherwise waits.
- **SEND**
  - Waits for the shifter's done.
  - Then enforces a 2-cycle gap with CS high (GAP).
- **GAP**
  - If dirty bits remain, returns to IDLE; the next word starts immediately.
  - Otherwise goes to LDAC.
- **LDAC**
  - Holds DAC_LDACn low for LDAC_W cycles.
  - Pulses done, then returns to IDLE.

**Requests.** Requests are accepted in every state except INIT.
- At most one ack per cycle.
- Host has fixed priority over cal; a losing requester keeps req high and is acked on a later cycle.
- On ack with ch ≤ 4: shadow[ch] ← val and dirty[ch] ← 1, both in the ack cycle.
- On ack with ch > 4: err_ch pulses and nothing is written.

**Boundary conditions.**
- **Write to a channel that is in flight:** the word already latched into the shifter is unaffected. The new value sets dirty again and is resent before LDAC.
- **Same channel written by both requesters on consecutive cycles:** last writer wins, and only one resend occurs if the channel is not yet launched.
- **update_all during INIT:** ignored.
- **update_all in any other state:** sets all dirty bits, merged with any pending bits.
- **Requests arriving during LDAC:** set dirty bits and produce a new batch after done.
- **rst asserted mid-operation:** all state and shadows clear immediately and INIT restarts.

## Timing
**Reset values.** DAC_CS=1, DAC_SDI=0, DAC_SCK=0, DAC_LDACn=1; host_ack, cal_ack, busy, done, dac_en and err_ch are all 0.

**Shifter start at cycle T.**
- T+1: CS=0, SDI=bit23, SCK=0.
- Each bit: SCK low for CLK_DIV cycles, then high for CLK_DIV cycles. SDI changes only on the SCK falling transition, so it is stable at every rising edge.
- T+1+48·CLK_DIV: SCK=0, CS=1, SDI=0, and shifter done pulses.

**Batches.**
- Word-to-word start spacing: 48·CLK_DIV+3 cycles.
- busy rises the cycle after the first launch and falls with done.
- A single-channel update at CLK_DIV=1: ack at A, shifter start at A+1, LDACn low A+52..A+51+LDAC_W, done at A+52+LDAC_W.

## Structure
- **Package drs_dac_pkg:**
  - command-byte constants CMD_ROFS..CMD_CALN and CMD_CFG0..2;
  - NCH=5;
  - state enum INIT/IDLE/SEND/GAP/LDAC;
  - 24-bit word typedef.
- **Sub-module drs_dac_spi_tx** (params CLK_DIV; ports clk, rst, start, word[23:0], CS, SDI, SCK, busy, done). It owns pin timing. The scheduler owns the shadows, dirty mask, arbitration, INIT sequencing and LDAC.

## Test plan
- Reset release, CLK_DIV=1 → exactly 8 words in order 0x330000, 0x370000, 0x360000, 0x320000, 0x310000, 0x400000, 0x440000, 0x450000; one LDACn pulse of 2 cycles; then dac_en=1.
- Host writes ch2=0xABCD → one word 0x36ABCD sampled on SCK rising edges; LDACn pulse; done; busy low afterwards.
- host_req (ch0=0x1111) and cal_req (ch4=0x2222) in the same cycle → host_ack first, cal_ack the next cycle; words 0x331111 then 0x312222; a single LDAC pulse.
- Cal rewrites ch1=0x0002 while 0x370001 is shifting → 0x370001 completes, then 0x370002 is sent, then one LDAC pulse.
- host_ch=6 → host_ack and err_ch pulse; no SPI activity.
- rst asserted during bit 10 of a word → CS=1 and SCK=0 asynchronously; after release the full INIT sequence repeats.

Source files
------------

// File: rtl/drs_dac_pkg.sv
// Shared constants and types for the DRS serial DAC scheduler.
// Command bytes per channel / config word, scheduler states, 24-bit word type.
package drs_dac_pkg;

    localparam int NCH = 5;

    localparam logic [7:0] CMD_ROFS = 8'h33;
    localparam logic [7:0] CMD_OOFS = 8'h37;
    localparam logic [7:0] CMD_BIAS = 8'h36;
    localparam logic [7:0] CMD_CALP = 8'h32;
    localparam logic [7:0] CMD_CALN = 8'h31;
    localparam logic [7:0] CMD_CFG0 = 8'h40;
    localparam logic [7:0] CMD_CFG1 = 8'h44;
    localparam logic [7:0] CMD_CFG2 = 8'h45;

    typedef enum logic [2:0] {INIT, IDLE, SEND, GAP, LDAC} state_t;

    typedef logic [23:0] dac_word_t;

    // Indices 0..4 are the analog channels, 5..7 the power-up config words.
    function automatic logic [7:0] cmd_of(input logic [2:0] idx);
        case (idx)
            3'd0:    return CMD_ROFS;
            3'd1:    return CMD_OOFS;
            3'd2:    return CMD_BIAS;
            3'd3:    return CMD_CALP;
            3'd4:    return CMD_CALN;
            3'd5:    return CMD_CFG0;
            3'd6:    return CMD_CFG1;
            default: return CMD_CFG2;
        endcase
    endfunction

endpackage

// File: rtl/drs_dac_spi_tx.sv
// Serial shifter: sends one 24-bit word MSB first on CS/SDI/SCK.
// Latency: CS low the cycle after start, done pulses 48*CLK_DIV+1 cycles after start.
// Backpressure: start is ignored while busy; SDI only changes on SCK falling.
module drs_dac_spi_tx #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] word,
    output logic        CS,
    output logic        SDI,
    output logic        SCK,
    output logic        busy,
    output logic        done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [23:0]   shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CS      <= 1'b1;
            SDI     <= 1'b0;
            SCK     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy    <= 1'b1;
                CS      <= 1'b0;
                SDI     <= word[23];
                SCK     <= 1'b0;
                shreg   <= {word[22:0], 1'b0};
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (busy) begin
                if (div_cnt == DW'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    if (!SCK) begin
                        SCK <= 1'b1;
                    end else begin
                        SCK <= 1'b0;
                        if (bit_cnt == 5'd23) begin
                            busy <= 1'b0;
                            CS   <= 1'b1;
                            SDI  <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            SDI     <= shreg[23];
                            shreg   <= {shreg[22:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/drs_dac_sched.sv
// DRS DAC scheduler: shadow bank, host/cal arbitration, dirty-channel resend, INIT and LDAC.
// Latency: ack to shifter start 1 cycle; last word done to LDACn low 2 cycles.
// Backpressure: requests acked one per cycle (host first) once dac_en; req held until ack.
module drs_dac_sched import drs_dac_pkg::*; #(
    parameter int CLK_DIV = 1,
    parameter int LDAC_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic [2:0]  host_ch,
    input  logic [15:0] host_val,
    output logic        host_ack,
    input  logic        cal_req,
    input  logic [2:0]  cal_ch,
    input  logic [15:0] cal_val,
    output logic        cal_ack,
    input  logic        update_all,
    output logic        DAC_CS,
    output logic        DAC_SDI,
    output logic        DAC_SCK,
    output logic        DAC_LDACn,
    output logic        busy,
    output logic        done,
    output logic        dac_en,
    output logic        err_ch
);

    localparam int LW = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;

    state_t          state, state_n;
    logic [15:0]     shadow [NCH];
    logic [NCH-1:0]  dirty, clr_mask, set_mask;
    logic [2:0]      init_idx, pick;
    logic [LW-1:0]   lcnt;
    logic            ua_q, start, spi_busy, spi_done, ldac_last;
    logic            acc_vld, wr_ok;
    logic [2:0]      acc_ch;
    logic [15:0]     acc_val, init_val;
    dac_word_t       tx_word;

    assign host_ack  = dac_en && host_req;
    assign cal_ack   = dac_en && cal_req && !host_req;
    assign acc_vld   = host_ack || cal_ack;
    assign acc_ch    = host_ack ? host_ch  : cal_ch;
    assign acc_val   = host_ack ? host_val : cal_val;
    assign err_ch    = acc_vld && (acc_ch > 3'd4);
    assign wr_ok     = acc_vld && !err_ch;
    assign ldac_last = (state == LDAC) && (lcnt == LW'(LDAC_W - 1));
    assign DAC_LDACn = (state != LDAC);
    assign init_val  = (init_idx < 3'd5) ? shadow[init_idx] : 16'h0000;

    always_comb begin
        pick = 3'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (dirty[i]) pick = 3'(i);
        end
    end

    // update_all edges arriving before dac_en are dropped, not deferred.
    always_comb begin
        set_mask = (update_all && !ua_q && dac_en) ? '1 : '0;
        if (wr_ok) set_mask[acc_ch] = 1'b1;
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        tx_word  = '0;
        clr_mask = '0;
        case (state)
            INIT: begin
                if (!spi_busy) begin
                    start   = 1'b1;
                    tx_word = {cmd_of(init_idx), init_val};
                    state_n = SEND;
                end
            end
            IDLE: begin
                if ((|dirty) && !spi_busy) begin
                    start           = 1'b1;
                    tx_word         = {cmd_of(pick), shadow[pick]};
                    clr_mask[pick]  = 1'b1;
                    state_n         = SEND;
                end
            end
            SEND: begin
                if (spi_done) state_n = GAP;
            end
            GAP: begin
                if (!dac_en) state_n = (init_idx == 3'd7) ? LDAC : INIT;
                else         state_n = (|(dirty | set_mask)) ? IDLE : LDAC;
            end
            LDAC: begin
                if (ldac_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            dirty    <= '0;
            init_idx <= '0;
            lcnt     <= '0;
            ua_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dac_en   <= 1'b0;
            for (int i = 0; i < NCH; i++) shadow[i] <= '0;
        end else begin
            state <= state_n;
            ua_q  <= update_all;
            dirty <= (dirty & ~clr_mask) | set_mask;
            if (wr_ok) shadow[acc_ch] <= acc_val;
            if (state == GAP && !dac_en) init_idx <= init_idx + 3'd1;
            lcnt  <= (state == LDAC) ? lcnt + LW'(1) : '0;
            done  <= ldac_last;
            if (start)          busy <= 1'b1;
            else if (ldac_last) busy <= 1'b0;
            if (ldac_last) dac_en <= 1'b1;
        end
    end

    drs_dac_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .word  (tx_word),
        .CS    (DAC_CS),
        .SDI   (DAC_SDI),
        .SCK   (DAC_SCK),
        .busy  (spi_busy),
        .done  (spi_done)
    );

endmodule

// File: tb/tb_drs_dac_sched.sv
// Bench for drs_dac_sched: pin-level word decoder and LDAC/done monitor against
// an expected-word queue fed from a channel/value model and hand-computed words.
module tb_drs_dac_sched;

    localparam int CLK_DIV = 1;
    localparam int LDAC_W  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req, cal_req, update_all;
    logic [2:0]  host_ch, cal_ch;
    logic [15:0] host_val, cal_val;
    logic        host_ack, cal_ack;
    logic        DAC_CS, DAC_SDI, DAC_SCK, DAC_LDACn;
    logic        busy, done, dac_en, err_ch;

    drs_dac_sched #(.CLK_DIV(CLK_DIV), .LDAC_W(LDAC_W)) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_ch(host_ch), .host_val(host_val), .host_ack(host_ack),
        .cal_req(cal_req), .cal_ch(cal_ch), .cal_val(cal_val), .cal_ack(cal_ack),
        .update_all(update_all),
        .DAC_CS(DAC_CS), .DAC_SDI(DAC_SDI), .DAC_SCK(DAC_SCK), .DAC_LDACn(DAC_LDACn),
        .busy(busy), .done(done), .dac_en(dac_en), .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: what each channel currently holds, and the word it must produce.
    logic [15:0] m_shadow [5];
    logic [23:0] exp_q [$];

    function automatic logic [23:0] word_of(input int ch, input logic [15:0] v);
        logic [7:0] cmd;
        case (ch)
            0:       cmd = 8'h33;
            1:       cmd = 8'h37;
            2:       cmd = 8'h36;
            3:       cmd = 8'h32;
            default: cmd = 8'h31;
        endcase
        return {cmd, v};
    endfunction

    // Pin monitor: decodes words on SCK rising edges, checks LDAC width, done and spacing.
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_ldac = 1'b1;
    logic [23:0] shreg = '0;
    int nbits = 0, rx_cnt = 0, pulses = 0, cs_falls = 0, lw_cnt = 0;
    int cs_fall_cyc = 0, ldac_fall_cyc = 0, last_fall = -1, last_rise = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs = 1'b1; prev_sck = 1'b0; prev_ldac = 1'b1;
            nbits = 0; lw_cnt = 0; last_fall = -1; last_rise = 0;
        end else begin
            if (!DAC_CS && prev_cs) begin
                if (last_fall >= 0 && last_fall > last_rise)
                    check("word_spacing", cyc - last_fall, 48 * CLK_DIV + 3);
                last_fall = cyc; cs_fall_cyc = cyc; cs_falls++;
                nbits = 0; shreg = '0;
            end
            if (!DAC_CS && DAC_SCK && !prev_sck) begin
                shreg = {shreg[22:0], DAC_SDI};
                nbits++;
            end
            if (DAC_CS && !prev_cs) begin
                check("word_bits", nbits, 24);
                check("word_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("word", shreg, exp_q.pop_front());
                rx_cnt++;
            end
            if (!DAC_LDACn) begin
                if (prev_ldac) ldac_fall_cyc = cyc;
                lw_cnt++;
            end else if (!prev_ldac) begin
                check("ldac_width", lw_cnt, LDAC_W);
                check("busy_at_done", busy, 0);
                pulses++; lw_cnt = 0; last_rise = cyc;
            end
            check("done_after_ldac", done, DAC_LDACn && !prev_ldac);
            prev_cs = DAC_CS; prev_sck = DAC_SCK; prev_ldac = DAC_LDACn;
        end
    end

    task automatic req_write(input bit is_cal, input int ch, input logic [15:0] val,
                             output int ack_cyc, output logic err_seen);
        @(posedge clk); #1;
        if (is_cal) begin cal_req = 1; cal_ch = 3'(ch); cal_val = val; end
        else        begin host_req = 1; host_ch = 3'(ch); host_val = val; end
        ack_cyc = -1; err_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_cal ? cal_ack : host_ack) begin
                ack_cyc = cyc; err_seen = err_ch; break;
            end
        end
        @(posedge clk); #1;
        host_req = 0; cal_req = 0;
        check("ack_seen", ack_cyc >= 0, 1);
        if (ack_cyc >= 0 && ch <= 4) m_shadow[ch] = val;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin dc = cyc; break; end
        end
        check("done_seen", dc >= 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_dac_en(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dac_en) break;
        end
        check("dac_en_seen", dac_en, 1);
        @(negedge clk);
    endtask

    task automatic push_init();
        logic [23:0] iw [8];
        iw = '{24'h330000, 24'h370000, 24'h360000, 24'h320000,
               24'h310000, 24'h400000, 24'h440000, 24'h450000};
        for (int i = 0; i < 8; i++) exp_q.push_back(iw[i]);
        for (int i = 0; i < 5; i++) m_shadow[i] = 16'h0000;
    endtask

    initial begin
        int a, d, r0, p0, c0;
        logic e;
        host_req = 0; host_ch = 0; host_val = 0;
        cal_req = 0; cal_ch = 0; cal_val = 0; update_all = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", DAC_CS, 1);       check("rst_sdi", DAC_SDI, 0);
        check("rst_sck", DAC_SCK, 0);     check("rst_ldacn", DAC_LDACn, 1);
        check("rst_host_ack", host_ack, 0); check("rst_cal_ack", cal_ack, 0);
        check("rst_busy", busy, 0);       check("rst_done", done, 0);
        check("rst_dac_en", dac_en, 0);   check("rst_err_ch", err_ch, 0);

        // Power-up sequence.
        push_init();
        @(posedge clk); #1 rst = 0;
        wait_dac_en(1500);
        check("init_words", rx_cnt, 8);
        check("init_ldac_pulses", pulses, 1);
        check("init_queue_empty", exp_q.size(), 0);

        // Single host write: latency pinned by hand.
        r0 = rx_cnt; p0 = pulses;
        exp_q.push_back(24'h36ABCD);
        req_write(0, 2, 16'hABCD, a, e);
        wait_done(300, d);
        check("lat_cs_fall", cs_fall_cyc - a, 2);
        check("lat_ldac_fall", ldac_fall_cyc - a, 52);
        check("lat_done", d - a, 52 + LDAC_W);
        check("single_busy_after", busy, 0);
        check("single_words", rx_cnt - r0, 1);
        check("single_pulses", pulses - p0, 1);

        // Host and cal in the same cycle.
        r0 = rx_cnt; p0 = pulses;
        exp_q.push_back(24'h331111);
        exp_q.push_back(24'h312222);
        @(posedge clk); #1;
        host_req = 1; host_ch = 0; host_val = 16'h1111;
        cal_req = 1; cal_ch = 4; cal_val = 16'h2222;
        @(negedge clk);
        check("arb_host_ack", host_ack, 1); check("arb_cal_held", cal_ack, 0);
        @(posedge clk); #1 host_req = 0;
        @(negedge clk);
        check("arb_cal_ack", cal_ack, 1); check("arb_host_quiet", host_ack, 0);
        @(posedge clk); #1 cal_req = 0;
        m_shadow[0] = 16'h1111; m_shadow[4] = 16'h2222;
        wait_done(400, d);
        check("arb_words", rx_cnt - r0, 2);
        check("arb_pulses", pulses - p0, 1);

        // Rewrite of the channel currently shifting.
        r0 = rx_cnt; p0 = pulses;
        exp_q.push_back(24'h370001);
        exp_q.push_back(24'h370002);
        req_write(0, 1, 16'h0001, a, e);
        for (int i = 0; i < 50 && DAC_CS; i++) @(negedge clk);
        check("inflight_cs_low", DAC_CS, 0);
        repeat (5) @(negedge clk);
        req_write(1, 1, 16'h0002, a, e);
        wait_done(400, d);
        check("inflight_words", rx_cnt - r0, 2);
        check("inflight_pulses", pulses - p0, 1);

        // Bad channel: acked with err_ch, nothing sent.
        r0 = rx_cnt; p0 = pulses; c0 = cs_falls;
        req_write(0, 6, 16'h1234, a, e);
        check("err_ch_pulse", e, 1);
        repeat (120) @(negedge clk);
        check("err_no_cs", cs_falls - c0, 0);
        check("err_no_ldac", pulses - p0, 0);
        check("err_not_busy", busy, 0);

        // update_all resends all five channels from the model's shadow values.
        r0 = rx_cnt; p0 = pulses;
        for (int i = 0; i < 5; i++) exp_q.push_back(word_of(i, m_shadow[i]));
        @(posedge clk); #1 update_all = 1;
        @(posedge clk); #1 update_all = 0;
        wait_done(800, d);
        check("ua_words", rx_cnt - r0, 5);
        check("ua_pulses", pulses - p0, 1);
        check("ua_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a word, then full INIT again.
        req_write(0, 3, 16'h5555, a, e);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!DAC_CS && nbits >= 11) break;
        end
        check("mid_word_reached", !DAC_CS && nbits >= 10, 1);
        #2 rst = 1;
        #1;
        check("async_rst_cs", DAC_CS, 1);
        check("async_rst_sck", DAC_SCK, 0);
        check("async_rst_dac_en", dac_en, 0);
        check("rst_queue_empty", exp_q.size(), 0);
        r0 = rx_cnt; p0 = pulses;
        push_init();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        wait_dac_en(1500);
        check("reinit_words", rx_cnt - r0, 8);
        check("reinit_pulses", pulses - p0, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
